// File: rtl/shared_bv_half_serializer.sv
// shared_bv_half_serializer: buffers one shared full-width word and emits it as two share-wise half beats, low half first.
// Optional macro SPLIT_SERIAL_REFRESH_EN adds in_r and remasks the word on accept.
module shared_bv_half_serializer #(
    parameter int NUM_SHARES = 2,
    parameter int HALF_WIDTH = 15
) (
    input  logic                                      in_clock,
    input  logic                                      in_reset_n,
    input  logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0]   in_a,
`ifdef SPLIT_SERIAL_REFRESH_EN
    input  logic [NUM_SHARES-2:0][2*HALF_WIDTH-1:0]   in_r,
`endif
    input  logic                                      in_a_valid,
    output logic                                      out_a_ready,
    output logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]     out_b,
    output logic                                      out_b_valid,
    input  logic                                      in_b_ready,
    output logic                                      out_b_last
);
    localparam int BW = 2 * HALF_WIDTH;

    typedef enum logic [1:0] {IDLE = 2'b00, SEND_LO = 2'b01, SEND_HI = 2'b10} state_t;

    state_t state, state_next;
    logic [NUM_SHARES-1:0][BW-1:0] buffer, fresh;
    logic accept, transfer;

`ifdef SPLIT_SERIAL_REFRESH_EN
    logic [BW-1:0] mask;
    // The last share absorbs every mask so the unmasked value is preserved.
    always_comb begin
        fresh = in_a;
        mask = '0;
        for (int i = 0; i < NUM_SHARES - 1; i++) begin
            fresh[i] = in_a[i] ^ in_r[i];
            mask = mask ^ in_r[i];
        end
        fresh[NUM_SHARES-1] = in_a[NUM_SHARES-1] ^ mask;
    end
`else
    assign fresh = in_a;
`endif

    assign out_a_ready = (state == IDLE) || (state == SEND_HI && in_b_ready);
    assign out_b_valid = state[0] | state[1];
    assign out_b_last  = state[1];
    assign accept      = in_a_valid && out_a_ready;
    assign transfer    = out_b_valid && in_b_ready;

    // Half select comes only from registered state and buffer bits.
    always_comb begin
        out_b = '0;
        for (int i = 0; i < NUM_SHARES; i++)
            out_b[i] = state[0] ? buffer[i][HALF_WIDTH-1:0] : state[1] ? buffer[i][BW-1:HALF_WIDTH] : '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? SEND_LO : IDLE;
            SEND_LO: state_next = transfer ? SEND_HI : SEND_LO;
            SEND_HI: state_next = transfer ? (accept ? SEND_LO : IDLE) : SEND_HI;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state  <= IDLE;
            buffer <= '0;
        end else begin
            state <= state_next;
            if (accept)
                buffer <= fresh;
        end
    end
endmodule

// File: tb/tb_shared_bv_half_serializer.sv
// tb_shared_bv_half_serializer: randomized scoreboard bench; expected beats are queued on accept and popped on transfer.
module tb_shared_bv_half_serializer;
    localparam int NS = 2;
    localparam int HW = 15;
    localparam int BW = 30;

    logic clk = 0;
    logic rst_n = 0;
    logic [NS-1:0][BW-1:0] a = '0;
    logic a_valid = 0;
    logic a_ready;
    logic [NS-1:0][HW-1:0] b;
    logic b_valid;
    logic b_ready = 0;
    logic b_last;
`ifdef SPLIT_SERIAL_REFRESH_EN
    logic [NS-2:0][BW-1:0] r = '0;
`endif

    always #5 clk = ~clk;

    shared_bv_half_serializer #(.NUM_SHARES(NS), .HALF_WIDTH(HW)) dut (
        .in_clock(clk),
        .in_reset_n(rst_n),
        .in_a(a),
`ifdef SPLIT_SERIAL_REFRESH_EN
        .in_r(r),
`endif
        .in_a_valid(a_valid),
        .out_a_ready(a_ready),
        .out_b(b),
        .out_b_valid(b_valid),
        .in_b_ready(b_ready),
        .out_b_last(b_last)
    );

    typedef struct {
        logic [NS-1:0][HW-1:0] d;
        logic last;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int failures = 0;
    bit xfer = 0;
    bit acc = 0;
    beat_t nlo, nhi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the word the consumer should see, split share-wise into two halves.
    task automatic model_word(output beat_t lo, output beat_t hi);
        logic [NS-1:0][BW-1:0] w;
        logic [BW-1:0] m;
        w = a;
`ifdef SPLIT_SERIAL_REFRESH_EN
        m = '0;
        for (int i = 0; i < NS - 1; i++) begin
            w[i] = a[i] ^ r[i];
            m ^= r[i];
        end
        w[NS-1] = a[NS-1] ^ m;
`else
        m = '0;
`endif
        for (int i = 0; i < NS; i++) begin
            lo.d[i] = w[i][HW-1:0];
            hi.d[i] = w[i][BW-1:HW];
        end
        lo.last = 0;
        hi.last = 1;
    endtask

    // Monitor: compare outputs against the queue, decide what the next edge does.
    always @(negedge clk) begin
        if (rst_n) begin
            bit er;
            er = (q.size() == 0) || (q.size() == 1 && b_ready);
            chk("a_ready", 64'(a_ready), 64'(er));
            chk("b_valid", 64'(b_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("b_data", 64'(b), 64'(q[0].d));
                chk("b_last", 64'(b_last), 64'(q[0].last));
            end else begin
                chk("b_idle_zero", 64'({b, b_last}), 64'(0));
            end
            xfer = (q.size() != 0) && b_ready;
            acc = a_valid && er;
            if (acc) model_word(nlo, nhi);
        end else begin
            chk("rst_b_valid", 64'(b_valid), 64'(0));
            chk("rst_b_zero", 64'({b, b_last}), 64'(0));
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (xfer) void'(q.pop_front());
            if (acc) begin
                q.push_back(nlo);
                q.push_back(nhi);
            end
        end
        xfer = 0;
        acc = 0;
    end

    always @(negedge rst_n) begin
        q.delete();
        xfer = 0;
        acc = 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_word();
        for (int i = 0; i < NS; i++) a[i] = BW'($urandom());
`ifdef SPLIT_SERIAL_REFRESH_EN
        for (int i = 0; i < NS - 1; i++) r[i] = BW'($urandom());
`endif
    endtask

    initial begin
        rst_n = 0;
        repeat (3) step();
        rst_n = 1;
        #3;
        chk("reset_a_ready", 64'(a_ready), 64'(1));
        chk("reset_b_valid", 64'(b_valid), 64'(0));
        chk("reset_b_zero", 64'({b, b_last}), 64'(0));
        step();
        // Single known word.
        a[0] = {15'h1234, 15'h0ABC};
        a[1] = {15'h7FFF, 15'h0000};
`ifdef SPLIT_SERIAL_REFRESH_EN
        r[0] = 30'h2AAAAAAA;
`endif
        a_valid = 1;
        b_ready = 1;
        step();
        a_valid = 0;
        repeat (4) step();
        // Back-to-back: four words, ready held high.
        a_valid = 1;
        for (int k = 0; k < 8; k++) begin
            rand_word();
            step();
        end
        a_valid = 0;
        repeat (3) step();
        // Backpressure in SEND_LO, then SEND_HI.
        rand_word();
        a_valid = 1;
        b_ready = 0;
        step();
        a_valid = 1;
        rand_word();
        repeat (5) step();
        b_ready = 1;
        step();
        b_ready = 0;
        repeat (5) step();
        a_valid = 0;
        b_ready = 1;
        repeat (3) step();
        // Async reset while the high beat is stalled.
        rand_word();
        a_valid = 1;
        b_ready = 0;
        step();
        a_valid = 0;
        b_ready = 1;
        step();
        b_ready = 0;
        step();
        #2 rst_n = 0;
        #1;
        chk("async_rst_b_valid", 64'(b_valid), 64'(0));
        chk("async_rst_b_last", 64'(b_last), 64'(0));
        repeat (2) step();
        rst_n = 1;
        b_ready = 1;
        rand_word();
        a_valid = 1;
        step();
        a_valid = 0;
        repeat (3) step();
        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rand_word();
            a_valid = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        a_valid = 0;
        b_ready = 1;
        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shared_bv_half_serializer.md
Name: shared_bv_half_serializer

Overview:
Downstream-facing serializer for masked bitvectors. It accepts one full-width shared word (NUM_SHARES shares of 2*HALF_WIDTH bits) through a valid/ready handshake and stores it. It then emits the word as two half-width shared beats, low half first, through a second valid/ready handshake. It sits between a full-width masked datapath stage and a half-width consumer, such as a half-width S-box or key-schedule lane. Split is share-wise only: share i of each beat comes only from share i of the stored word, and shares are never combined.

Parameters:
NUM_SHARES, 2, number of Boolean shares per value (>=2)
HALF_WIDTH, 15, bits per emitted half; input width is BIT_WIDTH = 2*HALF_WIDTH

Ports:
in_clock  input  1  clock; all state updates on its rising edge
in_reset_n  input  1  reset, asynchronous, active-low
in_a  input  [NUM_SHARES][2*HALF_WIDTH]  shared full-width word
in_a_valid  input  1  in_a holds a valid word
out_a_ready  output  1  block accepts in_a this cycle
out_b  output  [NUM_SHARES][HALF_WIDTH]  shared half-width beat
out_b_valid  output  1  out_b holds a valid beat
in_b_ready  input  1  consumer accepts out_b this cycle
out_b_last  output  1  current beat is the high half (second beat)

Behaviour:
- Reset:
  - in_reset_n low asynchronously forces state IDLE and zeroes the buffer.
  - While in reset and after release: out_a_ready=1 (when in_reset_n high), out_b_valid=0, out_b=0, out_b_last=0.
  - Reset mid-operation discards the buffered word; no partial beat is emitted afterwards.
- Storage: one buffer register of NUM_SHARES x 2*HALF_WIDTH bits, plus a 2-bit state register.
- Input accept: a word is accepted on a rising edge where in_a_valid and out_a_ready are both 1.
- Output beat transfer: a beat is transferred on a rising edge where out_b_valid and in_b_ready are both 1.
- States:
  - IDLE:
    - out_a_ready=1; out_b_valid=0; out_b=0.
    - On accept: buffer<=in_a; go to SEND_LO.
  - SEND_LO:
    - out_a_ready=0; out_b_valid=1; out_b_last=0.
    - out_b[i] = buffer[i][HALF_WIDTH-1:0].
    - On transfer: go to SEND_HI.
    - Otherwise hold; out_b stays stable while stalled.
  - SEND_HI:
    - out_b_valid=1; out_b_last=1; out_b[i] = buffer[i][2*HALF_WIDTH-1:HALF_WIDTH].
    - out_a_ready = in_b_ready (combinational).
    - On transfer with simultaneous accept: buffer<=in_a; go to SEND_LO (back-to-back).
    - On transfer without accept: go to IDLE.
    - No transfer: hold.
- Timing:
  - Latency: word accepted at edge N gives its low beat valid in cycle N+1; high beat follows on the next transfer edge.
  - Throughput: one word per 2 cycles when in_b_ready is held at 1.
- Glitch and leakage rules:
  - out_b is selected from registered buffer bits only; the half-select is driven by state register bits only.
  - in_a never reaches out_b combinationally.
  - Only combinational path input to output: in_b_ready -> out_a_ready, in SEND_HI.
- Ignored inputs: in_a_valid in SEND_LO and in_a contents outside accept edges.

Optional Feature:
Macro SPLIT_SERIAL_REFRESH_EN.
- Defined:
  - Adds port in_r (input, [NUM_SHARES-1][2*HALF_WIDTH]) carrying fresh randomness.
  - On accept, buffer[i] <= in_a[i] ^ in_r[i] for i < NUM_SHARES-1.
  - buffer[NUM_SHARES-1] <= in_a[NUM_SHARES-1] ^ (XOR of all in_r[i]).
  - The unmasked value is unchanged. in_r is sampled only on accept edges.
- Undefined: no in_r port; buffer captures in_a verbatim.

Test Plan:
All scenarios use NUM_SHARES=2, HALF_WIDTH=15.
- Reset: hold in_reset_n=0 for 3 cycles, release -> out_a_ready=1, out_b_valid=0, out_b=0, out_b_last=0.
- Single word: in_a[0]={15'h1234,15'h0ABC}, in_a[1]={15'h7FFF,15'h0000}, in_b_ready=1 ->
  - cycle N+1: out_b=(0ABC,0000), last=0;
  - cycle N+2: out_b=(1234,7FFF), last=1;
  - cycle N+3: IDLE, out_b_valid=0.
- Back-to-back: 4 words offered continuously with in_b_ready=1 -> 8 beats in 8 consecutive cycles, last toggling 0,1; out_a_ready high only in IDLE and SEND_HI.
- Backpressure: in_b_ready=0 for 5 cycles during SEND_LO, then during SEND_HI -> out_b and out_b_last stable; no beat lost or duplicated; out_a_ready=0 throughout the stall.
- Async reset mid-word: assert in_reset_n=0 between edges during SEND_HI -> out_b_valid drops immediately; after release, the next word's low beat is emitted first.
- Refresh (SPLIT_SERIAL_REFRESH_EN): in_a as in the single-word case, in_r[0]=30'h2AAAAAAA -> out_b[0]^out_b[1] per beat equals 0ABC then 6DCB; share 0 low beat = 0ABC^2AAA = 2016.
